// File: rtl/pr_bus_arbiter_if.sv
// Processor-side device bus between the CPU M-stage, a DMA/debug master and the device decoder.
// The slave modport is the arbiter's view; the master modport is the requesters'/device's view.
interface pr_bus_arbiter_if;
  localparam int unsigned ADDR_W = 30;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  logic              cpu_req;
  logic              cpu_kill;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wd;
  logic [BE_W-1:0]   cpu_be;
  logic              cpu_we;
  logic [DATA_W-1:0] cpu_rd;
  logic              cpu_done;
  logic              cpu_err;
  logic              cpu_stall;

  logic              dma_req;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wd;
  logic [BE_W-1:0]   dma_be;
  logic              dma_we;
  logic              dma_gnt;
  logic [DATA_W-1:0] dma_rd;
  logic              dma_done;
  logic              dma_err;

  logic              dev_sel;
  logic [ADDR_W-1:0] dev_addr;
  logic [DATA_W-1:0] dev_wd;
  logic [BE_W-1:0]   dev_be;
  logic              dev_we;
  logic [DATA_W-1:0] dev_rd;
  logic              dev_rdy;

  modport slave (
    input  cpu_req, cpu_kill, cpu_addr, cpu_wd, cpu_be, cpu_we,
    output cpu_rd, cpu_done, cpu_err, cpu_stall,
    input  dma_req, dma_addr, dma_wd, dma_be, dma_we,
    output dma_gnt, dma_rd, dma_done, dma_err,
    output dev_sel, dev_addr, dev_wd, dev_be, dev_we,
    input  dev_rd, dev_rdy
  );

  modport master (
    output cpu_req, cpu_kill, cpu_addr, cpu_wd, cpu_be, cpu_we,
    input  cpu_rd, cpu_done, cpu_err, cpu_stall,
    output dma_req, dma_addr, dma_wd, dma_be, dma_we,
    input  dma_gnt, dma_rd, dma_done, dma_err,
    input  dev_sel, dev_addr, dev_wd, dev_be, dev_we,
    output dev_rd, dev_rdy
  );
endinterface

// File: rtl/pr_bus_arbiter.sv
// Two-master device bus arbiter: CPU-priority with DMA fairness cap, DevRdy wait states and
// a bus-error timeout that returns 32'hDEAD_BEEF.
module pr_bus_arbiter #(
  parameter int unsigned TIMEOUT    = 16,
  parameter int unsigned MAX_CONSEC = 4
) (
  input logic             clk,
  input logic             rst_n,
  pr_bus_arbiter_if.slave bus
);
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned WAIT_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned CONSEC_W = $clog2(MAX_CONSEC + 1);
  localparam logic [DATA_W-1:0] ERR_DATA = 32'hDEAD_BEEF;

  typedef enum logic { IDLE, ACC } state_t;
  typedef enum logic { OWN_CPU, OWN_DMA } owner_t;

  state_t              state;
  owner_t              owner;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [CONSEC_W-1:0] consec;

  logic              cpu_elig_c;
  logic              dma_elig_c;
  logic              dma_wins_c;
  logic              finish_c;
  logic [DATA_W-1:0] done_rd_c;

  // A master is not re-granted in its own Done cycle.
  assign cpu_elig_c = bus.cpu_req & ~bus.cpu_kill & ~bus.cpu_done;
  assign dma_elig_c = bus.dma_req & ~bus.dma_done;
  assign dma_wins_c = dma_elig_c & (~cpu_elig_c | (consec == CONSEC_W'(MAX_CONSEC)));

  // DevRdy beats the timeout when both land in the same cycle.
  assign finish_c  = bus.dev_rdy | (wait_cnt == WAIT_W'(TIMEOUT - 1));
  assign done_rd_c = bus.dev_rdy ? bus.dev_rd : ERR_DATA;

  assign bus.cpu_stall = bus.cpu_req & ~bus.cpu_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      owner        <= OWN_CPU;
      wait_cnt     <= '0;
      consec       <= '0;
      bus.cpu_rd   <= '0;
      bus.cpu_done <= 1'b0;
      bus.cpu_err  <= 1'b0;
      bus.dma_rd   <= '0;
      bus.dma_done <= 1'b0;
      bus.dma_err  <= 1'b0;
      bus.dma_gnt  <= 1'b0;
      bus.dev_sel  <= 1'b0;
      bus.dev_addr <= '0;
      bus.dev_wd   <= '0;
      bus.dev_be   <= '0;
      bus.dev_we   <= 1'b0;
    end else begin
      bus.cpu_done <= 1'b0;
      bus.cpu_err  <= 1'b0;
      bus.dma_done <= 1'b0;
      bus.dma_err  <= 1'b0;
      if (!bus.dma_req) consec <= '0;

      case (state)
        IDLE: begin
          if (cpu_elig_c || dma_elig_c) begin
            state       <= ACC;
            wait_cnt    <= '0;
            bus.dev_sel <= 1'b1;
            if (dma_wins_c) begin
              owner        <= OWN_DMA;
              bus.dma_gnt  <= 1'b1;
              bus.dev_addr <= bus.dma_addr;
              bus.dev_wd   <= bus.dma_wd;
              bus.dev_be   <= bus.dma_be;
              bus.dev_we   <= bus.dma_we;
              consec       <= '0;
            end else begin
              owner        <= OWN_CPU;
              bus.dev_addr <= bus.cpu_addr;
              bus.dev_wd   <= bus.cpu_wd;
              bus.dev_be   <= bus.cpu_be;
              bus.dev_we   <= bus.cpu_we;
              if (bus.dma_req && (consec != CONSEC_W'(MAX_CONSEC)))
                consec <= consec + CONSEC_W'(1);
            end
          end
        end
        ACC: begin
          if (finish_c) begin
            state       <= IDLE;
            bus.dev_sel <= 1'b0;
            bus.dev_we  <= 1'b0;
            bus.dma_gnt <= 1'b0;
            if (owner == OWN_DMA) begin
              bus.dma_rd   <= done_rd_c;
              bus.dma_done <= 1'b1;
              bus.dma_err  <= ~bus.dev_rdy;
            end else begin
              bus.cpu_rd   <= done_rd_c;
              bus.cpu_done <= 1'b1;
              bus.cpu_err  <= ~bus.dev_rdy;
            end
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
